shift_cmd_sequencer: RTL and testbench
======================================

Name: shift_cmd_sequencer

Overview:
- Upstream control stage for the team's bidirectional shift register (load / shift_dir / shift_en / parallel_in interface).
- Accepts one command at a time on a valid/ready handshake. A command carries a data word, a direction and a shift count.
- For each command: issues a one-cycle parallel load, then exactly N shift cycles in the requested direction, then pulses done.
- Optionally keeps a shadow model of the register contents and flags mismatches against the register's data_out.

Parameters:
- WIDTH, 4, data width of the shift register.
- CNT_W, 3, width of the shift-count field; max shifts per command = 2^CNT_W-1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command (high only in IDLE).
- cmd_data  input  WIDTH  word to parallel-load.
- cmd_dir  input  1  0 = shift left (toward MSB, zero into LSB); 1 = shift right (zero into MSB).
- cmd_count  input  CNT_W  number of shift cycles after the load.
- load  output  1  parallel-load strobe to the shift register.
- shift_en  output  1  shift strobe to the shift register.
- shift_dir  output  1  direction to the shift register.
- parallel_in  output  WIDTH  load data to the shift register.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse at command completion.
- data_out  input  WIDTH  shift register output; used only by the optional feature.
- mismatch  output  1  sticky shadow-compare error flag.

Behaviour:
- Reset (rst=1 at a rising edge, any state, including mid-command):
  - state goes to IDLE.
  - load, shift_en, shift_dir, done, busy, mismatch all 0; parallel_in = 0.
  - cmd_ready = 1 in the first cycle after rst deasserts.
  - A command in flight is dropped; no done is issued for it.
- All outputs are registered except cmd_ready and busy, which decode state.
- FSM states: IDLE, LOAD, SHIFT, DONE.
  - IDLE: cmd_ready=1. A command is accepted on an edge with cmd_valid && cmd_ready. On acceptance, capture data/dir/count and go to LOAD. While cmd_valid=0, stay in IDLE.
  - LOAD (exactly 1 cycle): load=1, shift_en=0, parallel_in=captured data, shift_dir=captured dir. Next state is DONE if count==0, else SHIFT with remaining=count.
  - SHIFT: load=0, shift_en=1, shift_dir held. remaining decrements every cycle. Go to DONE on the cycle where remaining==1, so exactly count shift cycles are issued.
  - DONE (1 cycle): done=1, load=0, shift_en=0. Next state is IDLE.
- Timing, with acceptance at edge k:
  - load is high in cycle k+1.
  - shift_en is high in cycles k+2 .. k+1+N.
  - done is high in cycle k+2+N.
  - cmd_ready returns in cycle k+3+N.
- load and shift_en are never high in the same cycle.
- parallel_in and shift_dir hold their captured values from LOAD until the next accepted command.
- cmd_valid and command fields are ignored outside IDLE. Upstream must hold cmd_valid and the command fields until acceptance.
- Back-to-back: with cmd_valid held high, the next command is accepted at the edge ending the first IDLE cycle after DONE. Minimum command period is N+3 cycles.
- cmd_count = maximum (all ones): exactly 2^CNT_W-1 shifts; the counter must not wrap early.

Optional Feature:
- Macro: SHIFT_SHADOW_CHECK_EN.
- Defined:
  - A WIDTH-bit shadow register mirrors the expected contents.
  - On the edge where load=1, shadow takes parallel_in.
  - On the edge where shift_en=1, shadow shifts in shift_dir with zero fill.
  - check_pending is a registered flag that is set the cycle after any load or shift strobe. In every cycle where check_pending=1, data_out is compared against shadow; on any difference, mismatch sets to 1.
  - mismatch is sticky; it is cleared only by rst or by acceptance of a new command.
- Not defined: no shadow logic; data_out is ignored; mismatch is tied to 0.

Test Plan:
- Left shift: after reset, cmd_data=1011, dir=0, count=2, single-cycle valid -> load in cycle k+1 with parallel_in=1011; shift_en high for 2 cycles with shift_dir=0; done in cycle k+4; register reads 0110 then 1100; mismatch stays 0.
- Right shift: cmd_data=1011, dir=1, count=2 -> register reads 0101 then 0010; done 4 cycles after acceptance.
- Zero count: count=0, data=1001 -> load for one cycle, no shift_en, done in cycle k+2, register holds 1001.
- Back-to-back with count=7: {0001, dir 0, count 7} then {1000, dir 1, count 1}, cmd_valid held high -> 7 shift cycles (register ends 0000); second command accepted exactly one cycle after the first done; cmd_ready low throughout the first command.
- Reset mid-SHIFT: count=5, rst asserted on the 2nd shift cycle -> next cycle all outputs are 0, busy=0, cmd_ready=1, and done never pulses.
- Shadow check (macro defined): force data_out one bit off for one cycle after a shift -> mismatch goes to 1 and stays 1; the next accepted command clears it. With the macro undefined, the same stimulus leaves mismatch at 0.

Source files
------------

// File: rtl/shift_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// shift_cmd_sequencer
//
// Upstream control stage for a bidirectional shift register. It accepts one
// command at a time on a valid/ready handshake. For each command it issues a
// one-cycle parallel load, then exactly cmd_count shift strobes in the
// requested direction, and then a one-cycle done pulse.
//
// Optional feature (macro SHIFT_SHADOW_CHECK_EN):
//   When the macro is defined, a shadow copy of the expected register contents
//   is kept and compared against data_out in the cycle after every load or
//   shift strobe. Any difference sets the sticky mismatch flag. The flag is
//   cleared by rst or when a new command is accepted. When the macro is not
//   defined, data_out is ignored and mismatch is tied to 0.
//
// Parameters:
//   WIDTH  - shift register data width
//   CNT_W  - shift-count width (up to 2^CNT_W-1 shifts per command)
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous, active-high reset
//   cmd_valid    command present
//   cmd_ready    command can be accepted (IDLE only)
//   cmd_data     word to parallel-load
//   cmd_dir      0 = shift left (toward MSB), 1 = shift right (toward LSB)
//   cmd_count    number of shift cycles after the load
//   load         parallel-load strobe (registered)
//   shift_en     shift strobe (registered)
//   shift_dir    shift direction (registered, held until next command)
//   parallel_in  load data (registered, held until next command)
//   busy         high whenever the FSM is not in IDLE
//   done         one-cycle completion pulse (registered)
//   data_out     shift register contents (used only by the shadow check)
//   mismatch     sticky shadow-compare error flag
// -----------------------------------------------------------------------------
module shift_cmd_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             load,
  output logic             shift_en,
  output logic             shift_dir,
  output logic [WIDTH-1:0] parallel_in,
  output logic             busy,
  output logic             done,
  input  logic [WIDTH-1:0] data_out,
  output logic             mismatch
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] remaining_q;
  logic             load_q;
  logic             shift_en_q;
  logic             shift_dir_q;
  logic             done_q;
  logic [WIDTH-1:0] parallel_in_q;
  logic             accept;

  assign accept    = cmd_valid && (state_q == S_IDLE);
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);

  // Strobes are registered: each branch sets the strobe that belongs to the
  // state being entered, so the output lines up with that state's cycle.
  always_ff @(posedge clk) begin
    // NOTE: every control register is cleared in reset so an aborted command
    // leaves no strobe or stale data behind; reset is synchronous here.
    if (rst) begin
      state_q       <= S_IDLE;
      remaining_q   <= '0;
      load_q        <= 1'b0;
      shift_en_q    <= 1'b0;
      shift_dir_q   <= 1'b0;
      done_q        <= 1'b0;
      parallel_in_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      load_q     <= 1'b0;
      shift_en_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q       <= S_LOAD;
            load_q        <= 1'b1;
            parallel_in_q <= cmd_data;
            shift_dir_q   <= cmd_dir;
            remaining_q   <= cmd_count;
          end
        end
        S_LOAD: begin
          if (remaining_q == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q    <= S_SHIFT;
            shift_en_q <= 1'b1;
          end
        end
        S_SHIFT: begin
          // Leave on the last shift cycle rather than counting to zero, so
          // the all-ones count yields exactly 2^CNT_W-1 shifts with no wrap.
          if (remaining_q == CNT_W'(1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            remaining_q <= remaining_q - CNT_W'(1);
            shift_en_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign load        = load_q;
  assign shift_en    = shift_en_q;
  assign shift_dir   = shift_dir_q;
  assign done        = done_q;
  assign parallel_in = parallel_in_q;

`ifdef SHIFT_SHADOW_CHECK_EN
  logic [WIDTH-1:0] shadow_q;
  logic [WIDTH-1:0] shadow_d;
  logic             check_pending_q;
  logic             mismatch_q;
  logic             mismatch_d;

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    shadow_d   = shadow_q;
    mismatch_d = mismatch_q;
    if (load_q) begin
      shadow_d = parallel_in_q;
    end else if (shift_en_q) begin
      shadow_d = shift_dir_q ? {1'b0, shadow_q[WIDTH-1:1]}
                             : {shadow_q[WIDTH-2:0], 1'b0};
    end
    // The register updates on the same edge as the shadow, so its output is
    // compared one cycle after each strobe.
    if (check_pending_q && (data_out != shadow_q)) begin
      mismatch_d = 1'b1;
    end
    if (accept) begin
      mismatch_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q        <= '0;
      check_pending_q <= 1'b0;
      mismatch_q      <= 1'b0;
    end else begin
      shadow_q        <= shadow_d;
      check_pending_q <= load_q || shift_en_q;
      mismatch_q      <= mismatch_d;
    end
  end

  assign mismatch = mismatch_q;
`else
  logic unused_data_out;
  assign unused_data_out = ^data_out;
  assign mismatch        = 1'b0;
`endif

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shift_cmd_sequencer
//
// Self-checking bench for shift_cmd_sequencer. A behavioural shift register
// is attached to the sequencer outputs and feeds data_out (with an optional
// one-bit corruption for the shadow-check sequence). A table of commands is
// run with cycle-exact strobe checks, followed by hand-written sequences for
// the left-shift intermediate values, back-to-back commands with the maximum
// count, reset in the middle of a command and the shadow-compare flag.
// -----------------------------------------------------------------------------
module tb_shift_cmd_sequencer;

  localparam int W = 4;
  localparam int C = 3;

`ifdef SHIFT_SHADOW_CHECK_EN
  localparam logic EXP_MM = 1'b1;
`else
  localparam logic EXP_MM = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] cmd_data;
  logic         cmd_dir;
  logic [C-1:0] cmd_count;
  logic         load;
  logic         shift_en;
  logic         shift_dir;
  logic [W-1:0] parallel_in;
  logic         busy;
  logic         done;
  logic [W-1:0] data_out;
  logic         mismatch;

  logic [W-1:0] sr_q;
  logic [W-1:0] corrupt;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [W-1:0] data;
    logic         dir;
    logic [C-1:0] count;
    logic [W-1:0] exp_reg;
  } vec_t;

  vec_t vecs[7];

  shift_cmd_sequencer #(.WIDTH(W), .CNT_W(C)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_data    (cmd_data),
    .cmd_dir     (cmd_dir),
    .cmd_count   (cmd_count),
    .load        (load),
    .shift_en    (shift_en),
    .shift_dir   (shift_dir),
    .parallel_in (parallel_in),
    .busy        (busy),
    .done        (done),
    .data_out    (data_out),
    .mismatch    (mismatch)
  );

  always #5 clk = ~clk;

  // Behavioural shift register driven by the sequencer strobes.
  always @(posedge clk) begin
    if (rst)           sr_q <= '0;
    else if (load)     sr_q <= parallel_in;
    else if (shift_en) sr_q <= shift_dir ? {1'b0, sr_q[W-1:1]} : {sr_q[W-2:0], 1'b0};
  end

  assign data_out = sr_q ^ corrupt;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Runs one command with a single-cycle valid and checks every cycle of it.
  // Starts and ends at a negedge with the sequencer idle.
  task automatic run_cmd(input vec_t v, input string tag);
    check({tag, "_ready_before"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_data  = v.data;
    cmd_dir   = v.dir;
    cmd_count = v.count;
    step();
    cmd_valid = 1'b0;
    check({tag, "_load"}, 32'(load), 32'd1);
    check({tag, "_load_no_shift"}, 32'(shift_en), 32'd0);
    check({tag, "_pin"}, 32'(parallel_in), 32'(v.data));
    check({tag, "_dir"}, 32'(shift_dir), 32'(v.dir));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_ready_low"}, 32'(cmd_ready), 32'd0);
    for (int i = 0; i < int'(v.count); i++) begin
      step();
      check({tag, "_shift_en"}, 32'(shift_en), 32'd1);
      check({tag, "_shift_no_load"}, 32'(load), 32'd0);
      check({tag, "_shift_dir"}, 32'(shift_dir), 32'(v.dir));
      check({tag, "_shift_no_done"}, 32'(done), 32'd0);
    end
    step();
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_done_no_shift"}, 32'(shift_en), 32'd0);
    check({tag, "_done_no_load"}, 32'(load), 32'd0);
    check({tag, "_reg"}, 32'(sr_q), 32'(v.exp_reg));
    step();
    check({tag, "_ready_after"}, 32'(cmd_ready), 32'd1);
    check({tag, "_done_cleared"}, 32'(done), 32'd0);
    check({tag, "_mismatch"}, 32'(mismatch), 32'd0);
  endtask

  initial begin
    vecs[0] = '{data: 4'b1011, dir: 1'b0, count: 3'd2, exp_reg: 4'b1100};
    vecs[1] = '{data: 4'b1011, dir: 1'b1, count: 3'd2, exp_reg: 4'b0010};
    vecs[2] = '{data: 4'b1001, dir: 1'b0, count: 3'd0, exp_reg: 4'b1001};
    vecs[3] = '{data: 4'b0110, dir: 1'b1, count: 3'd1, exp_reg: 4'b0011};
    vecs[4] = '{data: 4'b1111, dir: 1'b0, count: 3'd3, exp_reg: 4'b1000};
    vecs[5] = '{data: 4'b0101, dir: 1'b1, count: 3'd7, exp_reg: 4'b0000};
    vecs[6] = '{data: 4'b1000, dir: 1'b1, count: 3'd3, exp_reg: 4'b0001};

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    cmd_dir   = 1'b0;
    cmd_count = '0;
    corrupt   = '0;

    // Reset state.
    repeat (3) step();
    check("rst_load", 32'(load), 32'd0);
    check("rst_shift_en", 32'(shift_en), 32'd0);
    check("rst_shift_dir", 32'(shift_dir), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pin", 32'(parallel_in), 32'd0);
    check("rst_mismatch", 32'(mismatch), 32'd0);
    rst = 1'b0;
    step();
    check("rst_ready", 32'(cmd_ready), 32'd1);

    // Left shift with intermediate register values.
    cmd_valid = 1'b1;
    cmd_data  = 4'b1011;
    cmd_dir   = 1'b0;
    cmd_count = 3'd2;
    step();                                   // k+1
    cmd_valid = 1'b0;
    check("left_load", 32'(load), 32'd1);
    check("left_pin", 32'(parallel_in), 32'hB);
    step();                                   // k+2
    check("left_sh1", 32'(shift_en), 32'd1);
    check("left_reg_loaded", 32'(sr_q), 32'hB);
    step();                                   // k+3
    check("left_sh2", 32'(shift_en), 32'd1);
    check("left_reg_0110", 32'(sr_q), 32'h6);
    step();                                   // k+4
    check("left_done", 32'(done), 32'd1);
    check("left_reg_1100", 32'(sr_q), 32'hC);
    check("left_mismatch", 32'(mismatch), 32'd0);
    step();

    // Table of commands.
    for (int i = 0; i < 7; i++) begin
      run_cmd(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back with valid held high; first command uses the max count.
    cmd_valid = 1'b1;
    cmd_data  = 4'b0001;
    cmd_dir   = 1'b0;
    cmd_count = 3'd7;
    step();                                   // k+1, first accepted
    cmd_data  = 4'b1000;
    cmd_dir   = 1'b1;
    cmd_count = 3'd1;
    check("b2b_load1", 32'(load), 32'd1);
    check("b2b_ready_load", 32'(cmd_ready), 32'd0);
    for (int i = 0; i < 7; i++) begin
      step();                                 // k+2 .. k+8
      check("b2b_shift1", 32'(shift_en), 32'd1);
      check("b2b_ready_shift", 32'(cmd_ready), 32'd0);
    end
    step();                                   // k+9
    check("b2b_done1", 32'(done), 32'd1);
    check("b2b_ready_done", 32'(cmd_ready), 32'd0);
    check("b2b_reg1", 32'(sr_q), 32'h0);
    step();                                   // k+10, idle, accepts
    check("b2b_ready_idle", 32'(cmd_ready), 32'd1);
    check("b2b_no_load_idle", 32'(load), 32'd0);
    step();                                   // k+11
    cmd_valid = 1'b0;
    check("b2b_load2", 32'(load), 32'd1);
    check("b2b_pin2", 32'(parallel_in), 32'h8);
    check("b2b_dir2", 32'(shift_dir), 32'd1);
    step();                                   // k+12
    check("b2b_shift2", 32'(shift_en), 32'd1);
    step();                                   // k+13
    check("b2b_done2", 32'(done), 32'd1);
    check("b2b_reg2", 32'(sr_q), 32'h4);
    step();
    check("b2b_ready_end", 32'(cmd_ready), 32'd1);

    // Reset on the second shift cycle of a count-5 command.
    cmd_valid = 1'b1;
    cmd_data  = 4'b1111;
    cmd_dir   = 1'b0;
    cmd_count = 3'd5;
    step();                                   // k+1
    cmd_valid = 1'b0;
    step();                                   // k+2
    step();                                   // k+3
    check("rmid_shift2", 32'(shift_en), 32'd1);
    rst = 1'b1;
    step();                                   // k+4
    check("rmid_load", 32'(load), 32'd0);
    check("rmid_shift_en", 32'(shift_en), 32'd0);
    check("rmid_shift_dir", 32'(shift_dir), 32'd0);
    check("rmid_pin", 32'(parallel_in), 32'd0);
    check("rmid_done", 32'(done), 32'd0);
    check("rmid_busy", 32'(busy), 32'd0);
    check("rmid_mismatch", 32'(mismatch), 32'd0);
    rst = 1'b0;
    step();
    check("rmid_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      check("rmid_no_done", 32'(done), 32'd0);
      check("rmid_idle", 32'(busy), 32'd0);
    end

    // Shadow compare: data_out one bit off for one cycle after a shift.
    cmd_valid = 1'b1;
    cmd_data  = 4'b1011;
    cmd_dir   = 1'b0;
    cmd_count = 3'd2;
    step();                                   // k+1
    cmd_valid = 1'b0;
    step();                                   // k+2
    step();                                   // k+3
    check("shd_clean_before", 32'(mismatch), 32'd0);
    corrupt = 4'b0001;
    step();                                   // k+4
    corrupt = '0;
    check("shd_set", 32'(mismatch), 32'(EXP_MM));
    step();
    check("shd_idle", 32'(mismatch), 32'(EXP_MM));
    repeat (3) step();
    check("shd_sticky", 32'(mismatch), 32'(EXP_MM));
    cmd_valid = 1'b1;
    cmd_data  = 4'b0110;
    cmd_dir   = 1'b1;
    cmd_count = 3'd1;
    step();
    cmd_valid = 1'b0;
    check("shd_cleared", 32'(mismatch), 32'd0);
    repeat (3) step();
    check("shd_stays_clear", 32'(mismatch), 32'd0);
    check("shd_reg", 32'(sr_q), 32'h3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
